// File: rtl/hub75_scanner.sv
// hub75_scanner
//   Reads pixel-pair words from the framebuffer and drives a HUB75 panel chain
//   with 1/2^ROW_BITS scan and 4-plane binary-coded modulation. Shifting the
//   next row/plane overlaps the display of the previously latched one.
//   Ports:
//     sys_clk, rst         clock, asynchronous active-high reset
//     enable               run scanning; only looked at on frame boundaries
//     fb_raddr/fb_re       framebuffer read port ({row, col}); data returns next cycle
//     fb_rdata             [19:10] top-half pixel, [9:0] bottom-half, {R3,G4,B3}
//     frame_start          1-cycle pulse ahead of each frame's first read
//     hub_r1..hub_b2       colour bits of the plane being shifted
//     hub_a                row address of the displayed data
//     hub_clk/hub_lat      panel shift clock (sys_clk/2) and latch strobe
//     hub_oe_n             panel output enable, active-low
module hub75_scanner #(
  parameter int COL_BITS   = 9,
  parameter int ROW_BITS   = 5,
  parameter int BASE_TICKS = 8
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic                         enable,
  output logic [COL_BITS+ROW_BITS-1:0] fb_raddr,
  output logic                         fb_re,
  input  logic [19:0]                  fb_rdata,
  output logic                         frame_start,
  output logic                         hub_r1,
  output logic                         hub_g1,
  output logic                         hub_b1,
  output logic                         hub_r2,
  output logic                         hub_g2,
  output logic                         hub_b2,
  output logic [ROW_BITS-1:0]          hub_a,
  output logic                         hub_clk,
  output logic                         hub_lat,
  output logic                         hub_oe_n
);

  localparam int COLS  = 1 << COL_BITS;
  localparam int AW    = COL_BITS + ROW_BITS;
  localparam int SC_W  = COL_BITS + 2;
  localparam int CNT_W = $clog2(BASE_TICKS * 8 + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(2 * COLS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FSTART, S_WAIT2, S_SHIFT, S_WAITLAT, S_BLANK, S_LATCH
  } state_t;

  state_t              state_q, next_state;
  logic [SC_W-1:0]     sc_q;
  logic [ROW_BITS-1:0] shift_row_q;
  logic [1:0]          shift_plane_q;
  logic [CNT_W-1:0]    disp_cnt_q;
  logic [AW-1:0]       raddr_q;
  logic [AW-1:0]       cur_addr;
  logic                rd_vld_p0;
  logic                col_vld_p1;
  logic                shift_done;
  logic                disp_idle;
  logic                last_sub;

  // Bit p of the 4-bit widened channels: R and B are padded with a zero LSB.
  function automatic logic [2:0] plane_bits(input logic [9:0] px, input logic [1:0] p);
    logic [3:0] r4, g4, b4;
    r4 = {px[9:7], 1'b0};
    g4 = px[6:3];
    b4 = {px[2:0], 1'b0};
    return {r4[p], g4[p], b4[p]};
  endfunction

  // sc_q counts cycles inside a state; in SHIFT bit 0 is the column phase and
  // [COL_BITS:1] the column. The top bit marks the trailing clock/tail cycles.
  assign cur_addr   = {shift_row_q, sc_q[COL_BITS:1]};
  assign rd_vld_p0  = (state_q == S_SHIFT) && !sc_q[0] && !sc_q[SC_W-1];
  assign col_vld_p1 = (state_q == S_SHIFT) &&  sc_q[0] && !sc_q[SC_W-1];
  assign shift_done = (sc_q == SC_LAST);
  assign disp_idle  = (disp_cnt_q == '0);
  assign last_sub   = (shift_row_q == {ROW_BITS{1'b1}}) && (shift_plane_q == 2'd3);

  assign fb_re    = rd_vld_p0;
  assign fb_raddr = rd_vld_p0 ? cur_addr : raddr_q;
  assign hub_oe_n = disp_idle || (state_q == S_BLANK) || (state_q == S_LATCH);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= next_state;
  end

  always_comb begin
    next_state  = state_q;
    frame_start = 1'b0;
    hub_lat     = 1'b0;
    case (state_q)
      S_IDLE:    if (enable) next_state = S_FSTART;
      S_FSTART: begin
        frame_start = 1'b1;
        next_state  = S_WAIT2;
      end
      S_WAIT2:   if (sc_q[0]) next_state = S_SHIFT;
      S_SHIFT:   if (shift_done) next_state = disp_idle ? S_BLANK : S_WAITLAT;
      S_WAITLAT: if (disp_idle) next_state = S_BLANK;
      S_BLANK:   next_state = S_LATCH;
      S_LATCH: begin
        hub_lat = 1'b1;
        if (last_sub) next_state = enable ? S_FSTART : S_IDLE;
        else          next_state = S_SHIFT;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sc_q          <= '0;
      shift_row_q   <= '0;
      shift_plane_q <= '0;
      disp_cnt_q    <= '0;
      raddr_q       <= '0;
      hub_a         <= '0;
      hub_clk       <= 1'b0;
      hub_r1        <= 1'b0;
      hub_g1        <= 1'b0;
      hub_b1        <= 1'b0;
      hub_r2        <= 1'b0;
      hub_g2        <= 1'b0;
      hub_b2        <= 1'b0;
    end else begin
      sc_q <= (next_state == state_q) ? sc_q + SC_W'(1) : '0;

      // p0: read issued; the address is held for the idle phases.
      if (rd_vld_p0) raddr_q <= cur_addr;
      // Rising hub_clk lands one cycle after the data it clocks was set up.
      hub_clk <= (state_q == S_SHIFT) && !sc_q[0] && (sc_q != '0);

      // p1: read data returned, capture this plane's bits.
      if (col_vld_p1) begin
        {hub_r1, hub_g1, hub_b1} <= plane_bits(fb_rdata[19:10], shift_plane_q);
        {hub_r2, hub_g2, hub_b2} <= plane_bits(fb_rdata[9:0],   shift_plane_q);
      end

      if (state_q == S_BLANK) hub_a <= shift_row_q;

      // Leaving LATCH starts the display of the latched plane and moves the
      // shifter on to the next plane (and row after plane 3).
      if (state_q == S_LATCH) begin
        disp_cnt_q    <= CNT_W'(BASE_TICKS) << shift_plane_q;
        shift_plane_q <= shift_plane_q + 2'd1;
        if (shift_plane_q == 2'd3) shift_row_q <= shift_row_q + ROW_BITS'(1);
      end else if (!disp_idle) begin
        disp_cnt_q <= disp_cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hub75_scanner.sv
module tb_hub75_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en_a, en_b, en_c;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // A: COLS=4, 2 rows, BASE_TICKS=4, with a small synchronous RAM
  logic [2:0]  addr_a;
  logic        re_a, fs_a;
  logic [19:0] rdata_a = '0;
  logic [19:0] mem_a [8];
  logic        r1_a, g1_a, b1_a, r2_a, g2_a, b2_a;
  logic [0:0]  ha_a;
  logic        hclk_a, lat_a, oe_a;

  always @(posedge clk) if (re_a) rdata_a <= mem_a[addr_a];

  hub75_scanner #(.COL_BITS(2), .ROW_BITS(1), .BASE_TICKS(4)) dut_a (
    .sys_clk(clk), .rst(rst), .enable(en_a),
    .fb_raddr(addr_a), .fb_re(re_a), .fb_rdata(rdata_a), .frame_start(fs_a),
    .hub_r1(r1_a), .hub_g1(g1_a), .hub_b1(b1_a),
    .hub_r2(r2_a), .hub_g2(g2_a), .hub_b2(b2_a),
    .hub_a(ha_a), .hub_clk(hclk_a), .hub_lat(lat_a), .hub_oe_n(oe_a)
  );

  // B: COLS=4, BASE_TICKS=64 (display-limited)
  logic [2:0]  addr_b;
  logic        re_b, fs_b;
  logic        r1_b, g1_b, b1_b, r2_b, g2_b, b2_b;
  logic [0:0]  ha_b;
  logic        hclk_b, lat_b, oe_b;

  hub75_scanner #(.COL_BITS(2), .ROW_BITS(1), .BASE_TICKS(64)) dut_b (
    .sys_clk(clk), .rst(rst), .enable(en_b),
    .fb_raddr(addr_b), .fb_re(re_b), .fb_rdata(20'd0), .frame_start(fs_b),
    .hub_r1(r1_b), .hub_g1(g1_b), .hub_b1(b1_b),
    .hub_r2(r2_b), .hub_g2(g2_b), .hub_b2(b2_b),
    .hub_a(ha_b), .hub_clk(hclk_b), .hub_lat(lat_b), .hub_oe_n(oe_b)
  );

  // C: COLS=512, 32 rows, BASE_TICKS=8 (shift-limited)
  logic [13:0] addr_c;
  logic        re_c, fs_c;
  logic        r1_c, g1_c, b1_c, r2_c, g2_c, b2_c;
  logic [4:0]  ha_c;
  logic        hclk_c, lat_c, oe_c;

  hub75_scanner #(.COL_BITS(9), .ROW_BITS(5), .BASE_TICKS(8)) dut_c (
    .sys_clk(clk), .rst(rst), .enable(en_c),
    .fb_raddr(addr_c), .fb_re(re_c), .fb_rdata(20'd0), .frame_start(fs_c),
    .hub_r1(r1_c), .hub_g1(g1_c), .hub_b1(b1_c),
    .hub_r2(r2_c), .hub_g2(g2_c), .hub_b2(b2_c),
    .hub_a(ha_c), .hub_clk(hclk_c), .hub_lat(lat_c), .hub_oe_n(oe_c)
  );

  logic sel_c = 1'b0;
  logic mon_lat, mon_oe;
  assign mon_lat = sel_c ? lat_c : lat_b;
  assign mon_oe  = sel_c ? oe_c  : oe_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    en_c = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_fs_a(input string tag);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (fs_a) ok = 1;
    end
    chk({tag, "_fs_seen"}, ok, 1);
  endtask

  // Waits for a latch, checks its width and the following hub_oe_n low time.
  task automatic measure(input int exp_n, input string tag, output int t_lat);
    bit ok = 0;
    int w = 0;
    int n = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (mon_lat) ok = 1;
    end
    chk({tag, "_lat_seen"}, ok, 1);
    t_lat = cyc;
    while (mon_lat && w < 10) begin w++; @(negedge clk); end
    chk({tag, "_lat_width"}, w, 1);
    while (!mon_oe && n < 4000) begin n++; @(negedge clk); end
    chk({tag, "_oe_low"}, n, exp_n);
  endtask

  // Counts n latches on A; row for latch i of a frame is i/4.
  task automatic scan_latches(input int n, input string tag);
    int seen = 0;
    for (int i = 0; i < 4000 && seen < n; i++) begin
      @(negedge clk);
      if (lat_a) begin
        chk($sformatf("%s_hub_a%0d", tag, seen), ha_a, (seen % 8) / 4);
        seen++;
      end
    end
    chk({tag, "_latch_count"}, seen, n);
  endtask

  initial begin
    logic [3:0] exp_r1;
    logic [3:0] exp_b2;
    int pulses, fs_cnt, lat_cnt, t0, t1, t2, t3;
    logic prev;
    bit ok;

    for (int i = 0; i < 8; i++) mem_a[i] = '0;
    mem_a[1] = {10'b101_0000_000, 10'b000_0000_111};
    exp_r1 = 4'b1010;   // planes 3..0 of R4 = {3'b101,0}
    exp_b2 = 4'b1110;   // planes 3..0 of B4 = {3'b111,0}

    // Reset values
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe_n", oe_a, 1);
    chk("rst_lat", lat_a, 0);
    chk("rst_hclk", hclk_a, 0);
    chk("rst_re", re_a, 0);
    chk("rst_fs", fs_a, 0);
    chk("rst_hub_a", ha_a, 0);
    chk("rst_raddr", addr_a, 0);
    chk("rst_colour", {r1_a, g1_a, b1_a, r2_a, g2_a, b2_a}, 0);
    chk("rst_oe_n_c", oe_c, 1);
    rst = 1'b0;

    // Frame start and read sequence
    do_reset();
    en_a = 1'b1;
    wait_fs_a("start");
    @(negedge clk);
    chk("fs_width", fs_a, 0);
    chk("re_wait1", re_a, 0);
    @(negedge clk);
    chk("re_wait2", re_a, 0);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("re_slot%0d", k), re_a, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) chk($sformatf("raddr_col%0d", k / 2), addr_a, k / 2);
    end

    // BCM bits of column 1, row 0 over planes 0..3
    do_reset();
    en_a = 1'b1;
    pulses = 0;
    prev = 1'b0;
    for (int i = 0; i < 600 && pulses < 16; i++) begin
      @(negedge clk);
      if (hclk_a && !prev) begin
        if (pulses % 4 == 1) begin
          chk($sformatf("bcm_r1_p%0d", pulses / 4), r1_a, exp_r1[pulses / 4]);
          chk($sformatf("bcm_b2_p%0d", pulses / 4), b2_a, exp_b2[pulses / 4]);
          chk($sformatf("bcm_other_p%0d", pulses / 4), {g1_a, b1_a, r2_a, g2_a}, 0);
        end
        pulses++;
      end
      prev = hclk_a;
    end
    chk("bcm_pulses", pulses, 16);

    // Asynchronous reset in the middle of a row-1 shift
    do_reset();
    en_a = 1'b1;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (ha_a == 1'b1 && re_a) ok = 1;
    end
    chk("mid_shift_found", ok, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_oe_n", oe_a, 1);
    chk("async_lat", lat_a, 0);
    chk("async_hclk", hclk_a, 0);
    chk("async_re", re_a, 0);
    chk("async_fs", fs_a, 0);
    chk("async_hub_a", ha_a, 0);
    @(negedge clk);

    // Frame end with enable dropped mid-frame, then restart
    do_reset();
    en_a = 1'b1;
    wait_fs_a("f1");
    repeat (5) @(negedge clk);
    en_a = 1'b0;
    scan_latches(8, "f1");
    fs_cnt = 0;
    lat_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fs_a) fs_cnt++;
      if (lat_a) lat_cnt++;
    end
    chk("idle_no_fs", fs_cnt, 0);
    chk("idle_no_lat", lat_cnt, 0);
    chk("idle_oe_n", oe_a, 1);
    en_a = 1'b1;
    @(negedge clk);
    chk("restart_fs", fs_a, 1);
    scan_latches(8, "f2");

    // Display timing, display-limited
    do_reset();
    en_b = 1'b1;
    sel_c = 1'b0;
    measure(64,  "b_p0", t0);
    measure(128, "b_p1", t1);
    measure(256, "b_p2", t2);
    measure(512, "b_p3", t3);

    // Display timing, shift-limited
    do_reset();
    en_c = 1'b1;
    sel_c = 1'b1;
    measure(8,  "c_p0", t0);
    measure(16, "c_p1", t1);
    measure(32, "c_p2", t2);
    measure(64, "c_p3", t3);
    chk("c_period1", t1 - t0, 1028);
    chk("c_period2", t2 - t1, 1028);
    chk("c_period3", t3 - t2, 1028);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
